// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared types and helpers for the operand-forwarding / load-use hazard unit.
//   fwd_entry_t      : one in-flight write tracked after EX {vld, we, ld, rd}
//   FWD_RD_W         : storage width of rd in a tracker entry (AW must be <= 8)
//   FWD_ENTRY_W      : packed width of fwd_entry_t
//   FWD_SEL_RF       : forward select meaning "read the register file"
//   youngest_match() : index of the lowest set bit of an 8-bit match vector
// -----------------------------------------------------------------------------
package fwd_pkg;

  localparam int FWD_RD_W = 8;

  typedef struct packed {
    logic                vld;
    logic                we;
    logic                ld;
    logic [FWD_RD_W-1:0] rd;
  } fwd_entry_t;

  localparam int         FWD_ENTRY_W = $bits(fwd_entry_t);
  localparam logic [2:0] FWD_SEL_RF  = 3'd0;

  // Lowest set index wins (index 0 = youngest). Returns 0 when nothing is set,
  // so callers that keep bit 0 clear get FWD_SEL_RF for "no match".
  function automatic logic [2:0] youngest_match(input logic [7:0] match);
    logic [2:0] sel;
    sel = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      sel = match[k] ? 3'(k) : sel;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_hazard_chk.sv
// -----------------------------------------------------------------------------
// fwd_hazard_chk
// Checker for fwd_hazard_unit. Flags a youngest forward hit on a load that is
// still too young to be forwardable; legal stall behaviour makes this
// unreachable, so a firing means the surrounding pipeline misbehaved.
//   clk              in  clock
//   rst_n            in  active-low reset (checking disabled while low)
//   early_load_hit_i in  youngest-match-on-unforwardable-load indication
// -----------------------------------------------------------------------------
module fwd_hazard_chk (
  input logic clk,
  input logic rst_n,
  input logic early_load_hit_i
);

  a_no_early_load_fwd: assert property (@(posedge clk) disable iff (!rst_n) !early_load_hit_i);

endmodule

// File: rtl/fwd_tracker_stage.sv
// -----------------------------------------------------------------------------
// fwd_tracker_stage
// One post-EX tracker stage: a registered fwd_entry_t, cleared asynchronously.
//   clk     in  rising-edge clock
//   rst_n   in  asynchronous active-low reset (clears the entry, vld=0)
//   entry_i in  entry from the previous stage (or from EX for stage 1)
//   entry_o out registered entry
// -----------------------------------------------------------------------------
module fwd_tracker_stage
  import fwd_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FWD_ENTRY_W-1:0] entry_i,
  output logic [FWD_ENTRY_W-1:0] entry_o
);

  logic [FWD_ENTRY_W-1:0] entry_q;

  // Shift register: the tracker never holds, it advances every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= {FWD_ENTRY_W{1'b0}};
    end else begin
      entry_q <= entry_i;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Operand-forwarding select and load-use stall generation for the pipeline.
// In-flight writes are tracked in DEPTH post-EX stages (1=EX/MEM, 2=MEM/WB..).
// Optional feature macro: FWD_HAZARD_PERF_EN adds perf_stall_cnt/perf_fwd_cnt.
//   clk, rst_n      clock, asynchronous active-low reset
//   ex_valid/flush  EX holds a real instruction / EX instruction squashed
//   ex_regwrite     EX writes ex_rd;  ex_is_load: EX is a load
//   ex_src          EX source registers, operand i = [i*AW +: AW]
//   id_src/_used    ID source registers and per-operand "actually read" flags
//   fwd_sel         per-operand select, 0 = regfile, k = tracker stage k
//   fwd_stall       hold PC and IF/ID, inject a bubble into EX
//   perf_*_cnt      (FWD_HAZARD_PERF_EN only) saturating event counters
// AW up to 8 and DEPTH up to 7 are supported.
// -----------------------------------------------------------------------------
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int AW         = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ex_valid,
  input  logic                                  ex_flush,
  input  logic                                  ex_regwrite,
  input  logic                                  ex_is_load,
  input  logic [AW-1:0]                         ex_rd,
  input  logic [NUM_SRC*AW-1:0]                 ex_src,
  input  logic [NUM_SRC*AW-1:0]                 id_src,
  input  logic [NUM_SRC-1:0]                    id_src_used,
  output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]    fwd_sel,
  output logic                                  fwd_stall
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]                           perf_stall_cnt,
  output logic [31:0]                           perf_fwd_cnt
`endif
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  fwd_entry_t             ex_entry_s;
  logic [FWD_ENTRY_W-1:0] chain_s [0:DEPTH];   // [0] = entry offered by EX

  logic [AW-1:0]          f_src_s;
  logic [7:0]             f_hit_s;
  logic [7:0]             f_ld_s;
  logic [2:0]             f_sel_s;
  fwd_entry_t             f_ent_s;
  logic                   early_load_hit_s;

  logic [AW-1:0]          s_src_s;
  logic [7:0]             s_hit_s;
  logic [7:0]             s_ld_s;
  logic [2:0]             s_sel_s;
  fwd_entry_t             s_ent_s;
  logic                   stall_any_s;

  // Entry captured from EX: a squashed instruction and writes to r0 never count
  always_comb begin
    ex_entry_s     = '{default: 1'b0};
    ex_entry_s.vld = ex_valid & ~ex_flush;
    ex_entry_s.we  = ex_regwrite & (ex_rd != {AW{1'b0}});
    ex_entry_s.ld  = ex_is_load;
    ex_entry_s.rd  = FWD_RD_W'(ex_rd);
  end

  assign chain_s[0] = ex_entry_s;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    fwd_tracker_stage u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .entry_i (chain_s[k-1]),
      .entry_o (chain_s[k])
    );
  end

  // Forward select per EX operand: youngest matching tracker stage wins
  always_comb begin
    fwd_sel          = {(NUM_SRC*SEL_W){1'b0}};
    early_load_hit_s = 1'b0;
    f_src_s          = {AW{1'b0}};
    f_hit_s          = 8'd0;
    f_ld_s           = 8'd0;
    f_sel_s          = FWD_SEL_RF;
    f_ent_s          = '{default: 1'b0};
    for (int i = 0; i < NUM_SRC; i++) begin
      f_src_s = ex_src[i*AW +: AW];
      f_hit_s = 8'd0;
      f_ld_s  = 8'd0;
      for (int k = 1; k <= DEPTH; k++) begin
        f_ent_s    = fwd_entry_t'(chain_s[k]);
        f_hit_s[k] = f_ent_s.vld & f_ent_s.we & (f_ent_s.rd == FWD_RD_W'(f_src_s))
                     & (f_src_s != {AW{1'b0}});
        f_ld_s[k]  = f_ent_s.ld;
      end
      f_sel_s = youngest_match(f_hit_s);
      fwd_sel[i*SEL_W +: SEL_W] = f_sel_s[SEL_W-1:0];
      // Load data not yet available at the youngest producer: observed only
      early_load_hit_s = early_load_hit_s | ((f_sel_s != FWD_SEL_RF)
                         && (int'(f_sel_s) < LOAD_STAGE) && f_ld_s[f_sel_s]);
    end
  end

  // Load-use stall: youngest producer among EX and stages 1..LOAD_STAGE-2
  // decides, so an older load hidden behind a younger ALU write is harmless
  always_comb begin
    stall_any_s = 1'b0;
    s_src_s     = {AW{1'b0}};
    s_hit_s     = 8'd0;
    s_ld_s      = 8'd0;
    s_sel_s     = 3'd0;
    s_ent_s     = '{default: 1'b0};
    for (int i = 0; i < NUM_SRC; i++) begin
      s_src_s = id_src[i*AW +: AW];
      s_hit_s = 8'd0;
      s_ld_s  = 8'd0;
      for (int k = 0; k <= DEPTH; k++) begin
        s_ent_s    = fwd_entry_t'(chain_s[k]);
        s_hit_s[k] = (k <= LOAD_STAGE - 2 || k == 0) && s_ent_s.vld && s_ent_s.we
                     && (s_ent_s.rd == FWD_RD_W'(s_src_s));
        s_ld_s[k]  = s_ent_s.ld;
      end
      s_sel_s     = youngest_match(s_hit_s);
      stall_any_s = stall_any_s | (id_src_used[i] && (s_src_s != {AW{1'b0}})
                    && (s_hit_s != 8'd0) && s_ld_s[s_sel_s]);
    end
  end

  // With LOAD_STAGE=1 load data forwards from stage 1, so no bubble is needed
  assign fwd_stall = (LOAD_STAGE > 1) ? stall_any_s : 1'b0;

  fwd_hazard_chk u_chk (
    .clk              (clk),
    .rst_n            (rst_n),
    .early_load_hit_i (early_load_hit_s)
  );

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating next-state for both event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (fwd_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (ex_valid && (fwd_sel != {(NUM_SRC*SEL_W){1'b0}}) && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end else begin
      fwd_cnt_d = fwd_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      fwd_cnt_q   <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_fwd_cnt   = fwd_cnt_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int AW         = 5;
  localparam int NUM_SRC    = 2;
  localparam int DEPTH      = 2;
  localparam int LOAD_STAGE = 2;
  localparam int SEL_W      = $clog2(DEPTH + 1);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     ex_valid, ex_flush, ex_regwrite, ex_is_load;
  logic [AW-1:0]            ex_rd;
  logic [NUM_SRC*AW-1:0]    ex_src, id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     fwd_stall;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]              perf_stall_cnt, perf_fwd_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.AW(AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_src(ex_src), .id_src(id_src), .id_src_used(id_src_used),
    .fwd_sel(fwd_sel), .fwd_stall(fwd_stall)
`ifdef FWD_HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  // ---------------- reference model: history of retired-from-EX instructions
  typedef struct { bit vld; bit wr; bit ld; bit [AW-1:0] rd; } ent_t;
  ent_t hist[$];   // hist[0] = instruction that left EX most recently

  typedef struct { bit valid; bit rw; bit ld; bit [AW-1:0] rd;
                   bit [NUM_SRC*AW-1:0] src; bit [NUM_SRC-1:0] used; } instr_t;

  function automatic ent_t cur_ex();
    ent_t e;
    e.vld = ex_valid && !ex_flush;
    e.wr  = ex_regwrite && (ex_rd != 0);
    e.ld  = ex_is_load;
    e.rd  = ex_rd;
    return e;
  endfunction

  task automatic model_clear();
    ent_t blank;
    blank = '{vld: 1'b0, wr: 1'b0, ld: 1'b0, rd: '0};
    hist.delete();
    for (int k = 0; k < DEPTH; k++) hist.push_back(blank);
  endtask

  // Most recent instruction that still writes src, counting from stage 1
  function automatic int exp_sel_of(bit [AW-1:0] src);
    if (src == 0) return 0;
    for (int k = 0; k < DEPTH; k++)
      if (hist[k].vld && hist[k].wr && hist[k].rd == src) return k + 1;
    return 0;
  endfunction

  function automatic logic [NUM_SRC*SEL_W-1:0] exp_sel_vec();
    logic [NUM_SRC*SEL_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SRC; i++)
      v[i*SEL_W +: SEL_W] = SEL_W'(exp_sel_of(ex_src[i*AW +: AW]));
    return v;
  endfunction

  // Walk producers youngest-first (EX, then stages that cannot yet forward a load)
  function automatic bit exp_stall();
    ent_t prod[$];
    bit   st;
    st = 0;
    if (LOAD_STAGE == 1) return 0;
    prod.push_back(cur_ex());
    for (int k = 0; k < LOAD_STAGE - 2; k++) prod.push_back(hist[k]);
    for (int i = 0; i < NUM_SRC; i++) begin
      bit [AW-1:0] s;
      s = id_src[i*AW +: AW];
      if (id_src_used[i] && s != 0) begin
        foreach (prod[p]) begin
          if (prod[p].vld && prod[p].wr && prod[p].rd == s) begin
            if (prod[p].ld) st = 1;
            break;
          end
        end
      end
    end
    return st;
  endfunction

  // ---------------- drivers
  task automatic tick();
    @(posedge clk);
    hist.push_front(cur_ex());
    hist.delete(DEPTH);
    #1;
  endtask

  task automatic drive_ex(bit v, bit fl, bit rw, bit ld, bit [AW-1:0] rd,
                          bit [AW-1:0] s0, bit [AW-1:0] s1);
    ex_valid = v; ex_flush = fl; ex_regwrite = rw; ex_is_load = ld; ex_rd = rd;
    ex_src = {s1, s0};
  endtask

  task automatic drive_id(bit [AW-1:0] s0, bit [AW-1:0] s1, bit [1:0] used);
    id_src = {s1, s0}; id_src_used = used;
  endtask

  task automatic idle();
    drive_ex(0, 0, 0, 0, 0, 0, 0);
    drive_id(0, 0, 2'b00);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    tick();
  endtask

  // ---------------- tests
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_ex(1, 0, 1, 1, 5'd2, 5'd2, 5'd2);
    drive_id(5'd2, 5'd0, 2'b01);
    #2;
    n_checks++;
    if (fwd_sel !== '0) $display("FAIL reset_sel: got %0h expected 0", fwd_sel);
    else n_pass++;
    n_checks++;
    if (fwd_stall !== 1'b1) $display("FAIL reset_stall_from_inputs: got %0b expected 1", fwd_stall);
    else n_pass++;
    apply_reset();
    drive_ex(1, 0, 0, 0, 0, 5'd7, 5'd9);
    #1;
    n_checks++;
    if (fwd_sel !== '0 || fwd_stall !== 1'b0)
      $display("FAIL post_reset: got sel=%0h stall=%0b expected 0/0", fwd_sel, fwd_stall);
    else n_pass++;
  endtask

  task automatic test_forward();
    // 1: add r1 then consumer right behind
    apply_reset();
    drive_ex(1, 0, 1, 0, 5'd1, 5'd4, 5'd5); tick();
    drive_ex(1, 0, 0, 0, 5'd0, 5'd1, 5'd0);
    @(negedge clk);
    n_checks++;
    if (fwd_sel[0 +: SEL_W] !== 2'd1 || fwd_stall !== 1'b0)
      $display("FAIL fwd_stage1: got sel=%0d stall=%0b expected 1/0", fwd_sel[0 +: SEL_W], fwd_stall);
    else n_pass++;
    // 2: add r1, nop, consumer
    apply_reset();
    drive_ex(1, 0, 1, 0, 5'd1, 5'd0, 5'd0); tick();
    idle(); tick();
    drive_ex(1, 0, 0, 0, 5'd0, 5'd1, 5'd0);
    @(negedge clk);
    n_checks++;
    if (fwd_sel[0 +: SEL_W] !== 2'd2)
      $display("FAIL fwd_stage2: got %0d expected 2", fwd_sel[0 +: SEL_W]);
    else n_pass++;
    // 3: two writers of r3, youngest must win on operand 1
    apply_reset();
    drive_ex(1, 0, 1, 0, 5'd3, 5'd0, 5'd0); tick();
    drive_ex(1, 0, 1, 0, 5'd3, 5'd0, 5'd0); tick();
    drive_ex(1, 0, 0, 0, 5'd0, 5'd6, 5'd3);
    @(negedge clk);
    n_checks++;
    if (fwd_sel !== 4'b0100)
      $display("FAIL fwd_youngest: got %0h expected 4", fwd_sel);
    else n_pass++;
  endtask

  task automatic test_load_use();
    apply_reset();
    drive_ex(1, 0, 1, 1, 5'd2, 5'd0, 5'd0);
    drive_id(5'd2, 5'd0, 2'b01);
    @(negedge clk);
    n_checks++;
    if (fwd_stall !== 1'b1) $display("FAIL lu_stall: got %0b expected 1", fwd_stall);
    else n_pass++;
    tick();
    drive_ex(0, 0, 0, 0, 0, 0, 0);     // bubble, consumer held in ID
    @(negedge clk);
    n_checks++;
    if (fwd_stall !== 1'b0) $display("FAIL lu_one_cycle: got %0b expected 0", fwd_stall);
    else n_pass++;
    tick();
    drive_ex(1, 0, 0, 0, 5'd0, 5'd2, 5'd0);
    drive_id(0, 0, 2'b00);
    @(negedge clk);
    n_checks++;
    if (fwd_sel[0 +: SEL_W] !== 2'd2 || fwd_stall !== 1'b0)
      $display("FAIL lu_consumer: got sel=%0d stall=%0b expected 2/0", fwd_sel[0 +: SEL_W], fwd_stall);
    else n_pass++;
  endtask

  task automatic test_corner();
    // write to r0, and a regwrite=0 instruction: never forward
    apply_reset();
    drive_ex(1, 0, 1, 0, 5'd0, 5'd0, 5'd0); tick();
    drive_ex(1, 0, 0, 0, 5'd4, 5'd0, 5'd0); tick();
    drive_ex(1, 0, 0, 0, 5'd0, 5'd0, 5'd4);
    @(negedge clk);
    n_checks++;
    if (fwd_sel !== '0) $display("FAIL r0_nowrite: got %0h expected 0", fwd_sel);
    else n_pass++;
    // flushed lw r2: no stall, no forward afterwards
    apply_reset();
    drive_ex(1, 1, 1, 1, 5'd2, 5'd0, 5'd0);
    drive_id(5'd2, 5'd2, 2'b11);
    @(negedge clk);
    n_checks++;
    if (fwd_stall !== 1'b0) $display("FAIL flush_stall: got %0b expected 0", fwd_stall);
    else n_pass++;
    tick();
    drive_ex(1, 0, 0, 0, 5'd0, 5'd2, 5'd2);
    drive_id(0, 0, 2'b00);
    @(negedge clk);
    n_checks++;
    if (fwd_sel !== '0) $display("FAIL flush_fwd: got %0h expected 0", fwd_sel);
    else n_pass++;
    // unused operand must not stall
    apply_reset();
    drive_ex(1, 0, 1, 1, 5'd2, 5'd0, 5'd0);
    drive_id(5'd2, 5'd2, 2'b00);
    @(negedge clk);
    n_checks++;
    if (fwd_stall !== 1'b0) $display("FAIL unused_stall: got %0b expected 0", fwd_stall);
    else n_pass++;
    // load with rd=0 must not stall
    drive_ex(1, 0, 1, 1, 5'd0, 5'd0, 5'd0);
    drive_id(5'd0, 5'd0, 2'b11);
    @(negedge clk);
    n_checks++;
    if (fwd_stall !== 1'b0) $display("FAIL r0_load_stall: got %0b expected 0", fwd_stall);
    else n_pass++;
    idle();
  endtask

  task automatic test_midstream_reset();
    apply_reset();
    drive_ex(1, 0, 1, 0, 5'd1, 5'd0, 5'd0); tick();
    drive_ex(1, 0, 1, 0, 5'd2, 5'd0, 5'd0); tick();
    drive_ex(0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
    @(negedge clk);
    n_checks++;
    if (fwd_sel !== 4'b0110) $display("FAIL pre_reset_live: got %0h expected 6", fwd_sel);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (fwd_sel !== '0) $display("FAIL async_reset_sel: got %0h expected 0", fwd_sel);
    else n_pass++;
`ifdef FWD_HAZARD_PERF_EN
    n_checks++;
    if (perf_stall_cnt !== 32'd0 || perf_fwd_cnt !== 32'd0)
      $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_stall_cnt, perf_fwd_cnt);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    drive_ex(1, 0, 1, 1, 5'd2, 5'd0, 5'd0);
    drive_id(5'd2, 5'd0, 2'b01);
    tick();
    idle();
    #1;
    n_checks++;
    if (fwd_sel !== '0) $display("FAIL post_release_sel: got %0h expected 0", fwd_sel);
    else n_pass++;
`ifdef FWD_HAZARD_PERF_EN
    n_checks++;
    if (perf_stall_cnt !== 32'd1) $display("FAIL perf_resume: got %0d expected 1", perf_stall_cnt);
    else n_pass++;
`endif
  endtask

  function automatic instr_t rand_instr();
    instr_t n;
    n.valid = ($urandom_range(0, 5) != 0);
    n.rw    = ($urandom_range(0, 3) != 0);
    n.ld    = n.rw && ($urandom_range(0, 2) == 0);
    n.rd    = AW'($urandom_range(0, 3));
    for (int i = 0; i < NUM_SRC; i++) n.src[i*AW +: AW] = AW'($urandom_range(0, 3));
    n.used  = NUM_SRC'($urandom_range(0, 3));
    return n;
  endfunction

  // Legal in-order pipeline: ID advances to EX unless the model says stall
  task automatic test_random();
    instr_t id_i, ex_i, bub;
    logic [NUM_SRC*SEL_W-1:0] exp_v;
    bit exp_st;
    int exp_stall_cnt, exp_fwd_cnt;
    bub = '{valid: 0, rw: 0, ld: 0, rd: '0, src: '0, used: '0};
    exp_stall_cnt = 0; exp_fwd_cnt = 0;
    apply_reset();
    id_i = rand_instr();
    ex_i = bub;
    for (int c = 0; c < 400; c++) begin
      ex_valid = ex_i.valid; ex_flush = ($urandom_range(0, 7) == 0);
      ex_regwrite = ex_i.rw; ex_is_load = ex_i.ld; ex_rd = ex_i.rd; ex_src = ex_i.src;
      id_src = id_i.src; id_src_used = id_i.used;
      @(negedge clk);
      exp_v  = exp_sel_vec();
      exp_st = exp_stall();
      n_checks++;
      if (fwd_sel !== exp_v) $display("FAIL rand_sel c%0d: got %0h expected %0h", c, fwd_sel, exp_v);
      else n_pass++;
      n_checks++;
      if (fwd_stall !== exp_st) $display("FAIL rand_stall c%0d: got %0b expected %0b", c, fwd_stall, exp_st);
      else n_pass++;
      if (exp_st) exp_stall_cnt++;
      if (ex_valid && exp_v != 0) exp_fwd_cnt++;
      tick();
      if (exp_st) begin
        ex_i = bub;
      end else begin
        ex_i = id_i;
        for (int i = 0; i < NUM_SRC; i++)
          if (!id_i.used[i]) ex_i.src[i*AW +: AW] = '0;
        id_i = rand_instr();
      end
    end
`ifdef FWD_HAZARD_PERF_EN
    n_checks++;
    if (perf_stall_cnt !== 32'(exp_stall_cnt) || perf_fwd_cnt !== 32'(exp_fwd_cnt))
      $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d",
               perf_stall_cnt, perf_fwd_cnt, exp_stall_cnt, exp_fwd_cnt);
    else n_pass++;
`else
    if (exp_stall_cnt == 0 || exp_fwd_cnt == 0)
      $display("note: random run had %0d stall and %0d forward cycles", exp_stall_cnt, exp_fwd_cnt);
`endif
    idle();
  endtask

  initial begin
    idle();
    model_clear();
    test_reset();
    test_forward();
    test_load_use();
    test_corner();
    test_midstream_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
